// File: rtl/usb_pkg.sv
// Shared USB token/handshake/data definitions for the bitstream decoder.
// Holds the PID code enum, per-field bit lengths, the decoder state enum
// and a helper that tells whether a 4-bit PID value is one we decode.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_e;

    localparam int PID_LEN  = 8;
    localparam int ADDR_LEN = 7;
    localparam int ENDP_LEN = 4;
    localparam int DATA_LEN = 64;
    localparam int CNT_W    = 7;

    typedef enum logic [2:0] {
        IDLE,
        RECV_PID,
        RECV_ADDR,
        RECV_ENDP,
        RECV_DATA,
        DONE,
        FLUSH
    } dec_state_e;

    function automatic logic pid_known(logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_DATA0, PID_ACK, PID_NAK: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sipo_shiftreg.sv
// Serial-in parallel-out shift register filled LSB first.
// Ports:
//   clk, rst_L : clock, asynchronous active-low reset
//   en         : shift din in this cycle
//   clr        : clear the register; with en also high, din is loaded as
//                the first bit of a fresh field
//   din        : serial input bit
//   q          : parallel contents
// Each new bit enters at the MSB and moves toward bit 0, so after W shifts
// the first bit received sits in q[0].
module sipo_shiftreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_L,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)
            q <= '0;
        else if (clr)
            q <= en ? {din, {(W-1){1'b0}}} : '0;
        else if (en)
            q <= {din, q[W-1:1]};
    end

endmodule

// File: rtl/bitstream_decoder.sv
// Serial USB-style packet decoder. Collects PID, then addr/endp (OUT/IN) or
// a 64-bit payload (DATA0), and holds the decoded packet until acknowledged.
// Ports:
//   clk, rst_L  : clock, asynchronous active-low reset
//   inb         : serial line bit, consumed when in_sending=1 and pause=0
//   in_sending  : transmitter is driving a packet
//   pause       : inb not valid this cycle
//   pkt_taken   : consumer releases the held packet
//   pid/addr/endp/data : decoded fields
//   pkt_avail   : a complete packet is held on the field outputs
//   pid_err     : one-cycle pulse, bad PID check or unknown PID
//   trunc_err   : one-cycle pulse, in_sending dropped mid-packet
//   ovr_err     : sticky, bits offered while a packet was held
module bitstream_decoder
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_L,
    input  logic        inb,
    input  logic        in_sending,
    input  logic        pause,
    input  logic        pkt_taken,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic        pkt_avail,
    output logic        pid_err,
    output logic        trunc_err,
    output logic        ovr_err
);

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pid_err_d, trunc_err_d, ovr_err_d;
    logic             pid_en, pid_clr, fld_clr, addr_en, endp_en, data_en;
    logic [7:0]       pid_q;
    logic [7:0]       pid_byte;
    logic             consume;
    logic             receiving;

    assign consume   = in_sending & ~pause;
    // Full PID byte as it will look once the current bit is shifted in.
    assign pid_byte  = {inb, pid_q[7:1]};
    assign receiving = (state_q == RECV_PID) || (state_q == RECV_ADDR) ||
                       (state_q == RECV_ENDP) || (state_q == RECV_DATA);
    assign pid       = pid_q[3:0];
    assign pkt_avail = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pid_err   <= 1'b0;
            trunc_err <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pid_err   <= pid_err_d;
            trunc_err <= trunc_err_d;
            ovr_err   <= ovr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pid_err_d   = 1'b0;
        trunc_err_d = 1'b0;
        ovr_err_d   = ovr_err;
        pid_en      = 1'b0;
        pid_clr     = 1'b0;
        fld_clr     = 1'b0;
        addr_en     = 1'b0;
        endp_en     = 1'b0;
        data_en     = 1'b0;

        if (receiving && !in_sending) begin
            // Partial packet is thrown away; fields return to zero.
            state_d     = IDLE;
            cnt_d       = '0;
            trunc_err_d = 1'b1;
            pid_clr     = 1'b1;
            fld_clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (consume) begin
                        state_d = RECV_PID;
                        cnt_d   = CNT_W'(1);
                        pid_en  = 1'b1;
                        pid_clr = 1'b1;
                        fld_clr = 1'b1;
                    end
                end
                RECV_PID: begin
                    if (consume) begin
                        pid_en = 1'b1;
                        if (cnt_q == CNT_W'(PID_LEN - 1)) begin
                            cnt_d = '0;
                            if (pid_byte[7:4] != ~pid_byte[3:0] || !pid_known(pid_byte[3:0])) begin
                                state_d   = FLUSH;
                                pid_err_d = 1'b1;
                            end else begin
                                case (pid_byte[3:0])
                                    PID_OUT, PID_IN: state_d = RECV_ADDR;
                                    PID_DATA0:       state_d = RECV_DATA;
                                    default:         state_d = DONE;
                                endcase
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RECV_ADDR: begin
                    if (consume) begin
                        addr_en = 1'b1;
                        if (cnt_q == CNT_W'(ADDR_LEN - 1)) begin
                            cnt_d   = '0;
                            state_d = RECV_ENDP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RECV_ENDP: begin
                    if (consume) begin
                        endp_en = 1'b1;
                        if (cnt_q == CNT_W'(ENDP_LEN - 1)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RECV_DATA: begin
                    if (consume) begin
                        data_en = 1'b1;
                        if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Release beats an overrun bit offered in the same cycle.
                    if (pkt_taken) begin
                        state_d   = IDLE;
                        ovr_err_d = 1'b0;
                    end else if (consume) begin
                        ovr_err_d = 1'b1;
                    end
                end
                FLUSH: begin
                    if (!in_sending)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sipo_shiftreg #(.W(PID_LEN)) u_pid (
        .clk(clk), .rst_L(rst_L), .en(pid_en), .clr(pid_clr), .din(inb), .q(pid_q)
    );
    sipo_shiftreg #(.W(ADDR_LEN)) u_addr (
        .clk(clk), .rst_L(rst_L), .en(addr_en), .clr(fld_clr), .din(inb), .q(addr)
    );
    sipo_shiftreg #(.W(ENDP_LEN)) u_endp (
        .clk(clk), .rst_L(rst_L), .en(endp_en), .clr(fld_clr), .din(inb), .q(endp)
    );
    sipo_shiftreg #(.W(DATA_LEN)) u_data (
        .clk(clk), .rst_L(rst_L), .en(data_en), .clr(fld_clr), .din(inb), .q(data)
    );

endmodule

// File: tb/tb_bitstream_decoder.sv
// Self-checking bench for bitstream_decoder: directed scenarios plus a
// randomized packet loop, with expected fields derived from the packet
// format (bit lists built from the field values).
module tb_bitstream_decoder;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        inb = 1'b0, in_sending = 1'b0, pause = 1'b0, pkt_taken = 1'b0;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        pkt_avail, pid_err, trunc_err, ovr_err;

    int n_chk = 0, n_err = 0;
    int n_piderr = 0, n_trunc = 0;
    bit bq[$];

    bitstream_decoder dut (
        .clk(clk), .rst_L(rst_L), .inb(inb), .in_sending(in_sending),
        .pause(pause), .pkt_taken(pkt_taken), .pid(pid), .addr(addr),
        .endp(endp), .data(data), .pkt_avail(pkt_avail), .pid_err(pid_err),
        .trunc_err(trunc_err), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the active edge (value of the previous cycle).
    always @(posedge clk) begin
        if (pid_err)   n_piderr++;
        if (trunc_err) n_trunc++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit has_addr(input logic [3:0] p);
        return (p == 4'b0001) || (p == 4'b1001);
    endfunction

    // Build the serial bit list of a packet, every field LSB first.
    task automatic build_pkt(input logic [3:0] p, input logic [6:0] a,
                             input logic [3:0] e, input logic [63:0] d);
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(p[i]);
        for (int i = 0; i < 4; i++) bq.push_back(~p[i]);
        if (has_addr(p)) begin
            for (int i = 0; i < 7; i++) bq.push_back(a[i]);
            for (int i = 0; i < 4; i++) bq.push_back(e[i]);
        end else if (p == 4'b0011) begin
            for (int i = 0; i < 64; i++) bq.push_back(d[i]);
        end
    endtask

    task automatic step(input logic s, input logic pz, input logic b, input logic tk);
        in_sending = s; pause = pz; inb = b; pkt_taken = tk;
        @(negedge clk);
    endtask

    // Send bq with npause pause cycles scattered before random bits.
    task automatic send_bits(input int npause, input bit rnd_take, input logic exp_av);
        int pc[];
        pc = new[bq.size()];
        for (int j = 0; j < npause; j++) pc[$urandom_range(0, bq.size() - 1)]++;
        for (int i = 0; i < bq.size(); i++) begin
            repeat (pc[i]) step(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                                rnd_take ? 1'($urandom_range(0, 1)) : 1'b0);
            if (i == bq.size() - 1) chk("avail_before_last", pkt_avail, exp_av);
            step(1'b1, 1'b0, bq[i], rnd_take ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        in_sending = 1'b0; pause = 1'b0; pkt_taken = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input logic [3:0] p, input logic [6:0] a,
                             input logic [3:0] e, input logic [63:0] d);
        chk({tag, "_avail"}, pkt_avail, 1'b1);
        chk({tag, "_pid"}, pid, p);
        chk({tag, "_addr"}, addr, has_addr(p) ? a : 7'd0);
        chk({tag, "_endp"}, endp, has_addr(p) ? e : 4'd0);
        chk({tag, "_data"}, data, (p == 4'b0011) ? d : 64'd0);
        chk({tag, "_ovr"}, ovr_err, 1'b0);
    endtask

    task automatic take_pkt(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pkt_taken = 1'b0;
        chk({tag, "_released"}, pkt_avail, 1'b0);
    endtask

    task automatic send_pkt(input string tag, input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e, input logic [63:0] d, input int npause);
        build_pkt(p, a, e, d);
        send_bits(npause, 1'b1, 1'b0);
        check_pkt(tag, p, a, e, d);
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk({tag, "_held_data"}, data, (p == 4'b0011) ? d : 64'd0);
        take_pkt(tag);
    endtask

    initial begin
        logic [3:0] ptab [5];
        int pe, te;
        ptab[0] = 4'b0001; ptab[1] = 4'b1001; ptab[2] = 4'b0011;
        ptab[3] = 4'b0010; ptab[4] = 4'b1010;

        repeat (3) @(negedge clk);
        chk("rst_pid", pid, 4'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_avail", pkt_avail, 1'b0);
        chk("rst_errs", {pid_err, trunc_err, ovr_err}, 3'b000);
        rst_L = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // OUT addr=1101101 endp=1101, no pause.
        send_pkt("out", 4'b0001, 7'b1101101, 4'b1101, 64'd0, 0);
        // ACK.
        send_pkt("ack", 4'b0010, 7'd0, 4'd0, 64'd0, 0);
        // DATA0 with three pause cycles.
        send_pkt("data0", 4'b0011, 7'd0, 4'd0, 64'hDEAD_BEEF_0123_4567, 3);

        // Paused in_sending in IDLE must not start a packet.
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt("nak_after_pause", 4'b1010, 7'd0, 4'd0, 64'd0, 0);

        // Bad PID check: 0001 then 0000.
        pe = n_piderr; te = n_trunc;
        bq.delete();
        bq.push_back(1); bq.push_back(0); bq.push_back(0); bq.push_back(0);
        repeat (4) bq.push_back(0);
        send_bits(0, 1'b0, 1'b0);
        chk("piderr_pulse", pid_err, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk("piderr_single", pid_err, 1'b0);
        chk("flush_avail", pkt_avail, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("piderr_count", n_piderr - pe, 1);
        chk("flush_no_trunc", n_trunc - te, 0);
        send_pkt("ack_after_flush", 4'b0010, 7'd0, 4'd0, 64'd0, 1);

        // IN truncated after 10 bits.
        te = n_trunc;
        build_pkt(4'b1001, 7'h5A, 4'h6, 64'd0);
        bq = bq[0:9];
        send_bits(0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("trunc_pulse", trunc_err, 1'b1);
        chk("trunc_avail", pkt_avail, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("trunc_single", trunc_err, 1'b0);
        chk("trunc_count", n_trunc - te, 1);
        send_pkt("nak_after_trunc", 4'b1010, 7'd0, 4'd0, 64'd0, 0);

        // Overrun: hold OUT, offer an ACK, then release with a bit offered.
        build_pkt(4'b0001, 7'h33, 4'hC, 64'd0);
        send_bits(0, 1'b0, 1'b0);
        check_pkt("ovr_first", 4'b0001, 7'h33, 4'hC, 64'd0);
        build_pkt(4'b0010, 7'd0, 4'd0, 64'd0);
        send_bits(2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_set", ovr_err, 1'b1);
        chk("ovr_keep_pid", pid, 4'b0001);
        chk("ovr_keep_addr", addr, 7'h33);
        chk("ovr_keep_endp", endp, 4'hC);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        pkt_taken = 1'b0;
        chk("ovr_release_avail", pkt_avail, 1'b0);
        chk("ovr_cleared", ovr_err, 1'b0);
        // Dropped bit must not prefix the next packet.
        send_pkt("ack_after_ovr", 4'b0010, 7'd0, 4'd0, 64'd0, 0);

        // Reset mid DATA0.
        build_pkt(4'b0011, 7'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        bq = bq[0:29];
        send_bits(0, 1'b0, 1'b0);
        #2 rst_L = 1'b0;
        #1;
        chk("midrst_pid", pid, 4'd0);
        chk("midrst_data", data, 64'd0);
        chk("midrst_flags", {pkt_avail, pid_err, trunc_err, ovr_err}, 4'b0000);
        @(negedge clk);
        rst_L = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt("nak_after_rst", 4'b1010, 7'd0, 4'd0, 64'd0, 0);

        // Randomized packets.
        for (int k = 0; k < 30; k++) begin
            logic [3:0]  p;
            logic [6:0]  a;
            logic [3:0]  e;
            logic [63:0] d;
            p = ptab[$urandom_range(0, 4)];
            a = 7'($urandom);
            e = 4'($urandom);
            d = {$urandom, $urandom};
            send_pkt("rnd", p, a, e, d, $urandom_range(0, 8));
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
